// File: rtl/regfile_sb.sv
// Register file with NUM_RD registered read ports, one write port, hardwired r0
// and a per-register busy scoreboard. Define REGFILE_BYPASS_EN for write-first reads.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       claim_en_i,
  input  logic [ADDR_W-1:0]          claim_addr_i,
  output logic                       busy_any_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [ADDR_W-1:0]        ra [NUM_RD];
  logic                     wr_live;

  for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_ra
    assign ra[g] = rd_addr_i[g*ADDR_W +: ADDR_W];
  end

  assign wr_live = wr_en_i && (wr_addr_i != '0);

  // Write releases, claim sets afterwards so a same-cycle claim wins; r0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_live) busy_d[wr_addr_i] = 1'b0;
    if (claim_en_i && (claim_addr_i != '0)) busy_d[claim_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_en_i[p]) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (ra[p] == wr_addr_i)) begin
          rd_data_d[p*DATA_W +: DATA_W] = wr_data_i;
          rd_busy_d[p]                  = busy_d[ra[p]];
        end else begin
          rd_data_d[p*DATA_W +: DATA_W] = mem_q[ra[p]];
          rd_busy_d[p]                  = busy_q[ra[p]];
        end
`else
        rd_data_d[p*DATA_W +: DATA_W] = mem_q[ra[p]];
        rd_busy_d[p]                  = busy_q[ra[p]];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      if (wr_live) mem_q[wr_addr_i] <= wr_data_i;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_busy_o  = rd_busy_q;
  // Combinational reduction of the registered busy vector for drain logic.
  assign busy_any_o = |busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     claim_en;
  logic [ADDR_W-1:0]        claim_addr;
  logic                     busy_any;

  int tests = 0;
  int fails = 0;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_en_i(claim_en), .claim_addr_i(claim_addr), .busy_any_o(busy_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int p, input logic [ADDR_W-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic claim(input logic [ADDR_W-1:0] a);
    claim_en = 1'b1; claim_addr = a;
  endtask

  // Advance one edge, settle, then drop all strobes for the next step.
  task automatic tick();
    @(posedge clk);
    #1;
    rd_en = '0; wr_en = 1'b0; claim_en = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] d(input int p);
    return rd_data[p*DATA_W +: DATA_W];
  endfunction

  initial begin
    rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;

    // Writes and claims under reset are lost
    for (int i = 0; i < 4; i++) begin
      wr(ADDR_W'($urandom), $urandom); claim(ADDR_W'($urandom_range(1, 31)));
      rd(0, ADDR_W'(i)); rd(1, ADDR_W'(i + 1));
      tick();
    end
    check("rst_data", 64'(rd_data), 64'h0);
    check("rst_busy", 64'(rd_busy), 64'h0);
    check("rst_busy_any", 64'(busy_any), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd(0, ADDR_W'(i)); rd(1, ADDR_W'(31 - i));
      tick();
      check("post_rst_data", 64'(rd_data), 64'h0);
      check("post_rst_busy", 64'({busy_any, rd_busy}), 64'h0);
    end

    wr(5'd5, 32'hDEADBEEF); tick();
    rd(0, 5'd5); rd(1, 5'd5); tick();
    check("r5_p0", 64'(d(0)), 64'hDEADBEEF);
    check("r5_p1", 64'(d(1)), 64'hDEADBEEF);
    check("r5_busy", 64'(rd_busy), 64'h0);

    wr(5'd0, 32'h12345678); claim(5'd0); tick();
    check("r0_busy_any", 64'(busy_any), 64'h0);
    rd(0, 5'd0); rd(1, 5'd0); tick();
    check("r0_data", 64'(rd_data), 64'h0);
    check("r0_busy", 64'(rd_busy), 64'h0);

    claim(5'd7); tick();
    check("r7_busy_any_set", 64'(busy_any), 64'h1);
    rd(0, 5'd7); tick();
    check("r7_busy_rd", 64'(rd_busy[0]), 64'h1);
    wr(5'd7, 32'hA5); tick();
    rd(0, 5'd7); tick();
    check("r7_data", 64'(d(0)), 64'hA5);
    check("r7_busy_clr", 64'(rd_busy[0]), 64'h0);
    check("r7_busy_any_clr", 64'(busy_any), 64'h0);
    // Port 1 unread throughout: still holds DEADBEEF? no - last read was r0
    check("p1_hold", 64'(d(1)), 64'h0);

    claim(5'd9); tick();
    wr(5'd9, 32'h55); claim(5'd9); tick();
    check("r9_busy_any", 64'(busy_any), 64'h1);
    rd(1, 5'd9); tick();
    check("r9_data", 64'(d(1)), 64'h55);
    check("r9_busy", 64'(rd_busy[1]), 64'h1);
    check("r9_p0_hold", 64'(d(0)), 64'hA5);
    wr(5'd9, 32'h56); tick();
    check("r9_release", 64'(busy_any), 64'h0);

    wr(5'd3, 32'h1); tick();
    wr(5'd3, 32'h2); rd(0, 5'd3); tick();
    check("r3_same_cycle", 64'(d(0)), BYP ? 64'h2 : 64'h1);
    check("r3_same_busy", 64'(rd_busy[0]), 64'h0);
    rd(0, 5'd3); tick();
    check("r3_after", 64'(d(0)), 64'h2);

    // Write+claim+read of one register in one cycle
    wr(5'd12, 32'hC0FFEE); claim(5'd12); rd(1, 5'd12); tick();
    check("r12_data", 64'(d(1)), BYP ? 64'hC0FFEE : 64'h0);
    check("r12_busy", 64'(rd_busy[1]), BYP ? 64'h1 : 64'h0);
    check("r12_busy_any", 64'(busy_any), 64'h1);

    // Asynchronous reset between edges
    wr(5'd11, 32'h77); claim(5'd10); tick();
    rst = 1'b1; #1;
    check("async_busy_any", 64'(busy_any), 64'h0);
    check("async_data", 64'(rd_data), 64'h0);
    rst = 1'b0;
    rd(0, 5'd11); rd(1, 5'd5); tick();
    check("async_r11", 64'(d(0)), 64'h0);
    check("async_r5", 64'(d(1)), 64'h0);
    check("async_busy", 64'({busy_any, rd_busy}), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with N registered read ports, one write port, hardwired-zero register 0 and a per-register busy scoreboard for in-flight writes. Sits in the decode stage of the pipelined core. Decode claims a destination register when an instruction issues. Writeback writes the result and releases the claim. Read ports report operand data and whether that operand is still pending.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all registers and busy bits
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  registered busy flag of the addressed register
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_en  in  1  mark a destination register busy
- claim_addr  in  ADDR_W  register to claim
- busy_any  out  1  combinational OR of all busy bits; used by the drain/flush logic

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits. Entry 0 reads 0 at all times. Writes to address 0 are discarded.
- Write: when wr_en=1, entry wr_addr takes wr_data at the edge. The busy bit of wr_addr clears at the same edge.
- Claim: when claim_en=1 and claim_addr≠0, the busy bit of claim_addr sets at the edge. A claim to address 0 is ignored. Busy bit 0 is always 0.
- Claim and write to the same address in the same cycle: the claim wins and the busy bit ends at 1, because a newer producer has issued. The data write still happens.
- Claim of an already-busy register: the bit stays 1. No count is kept, so only the latest producer matters.
- Read, port p with rd_en[p]=1:
  - At the edge, rd_data[p] loads entry rd_addr[p] and rd_busy[p] loads its busy bit.
  - The read-versus-write-same-cycle result is set by the Configuration section.
- Read with rd_en[p]=0: rd_data[p] and rd_busy[p] hold their previous values.
- All ports are independent. Any number of ports may read the same address.
- No write-collision resolution is needed, because there is a single write port.

## Timing
- Read latency: 1 cycle. Address is presented in cycle N; data and busy are valid after the edge ending cycle N.
- Write and claim take effect at the edge ending the cycle in which they are presented.
- busy_any reflects the busy vector after the most recent edge, with zero extra latency.
- Reset values: rd_data=0, rd_busy=0, busy_any=0, all entries 0, all busy bits 0.
- Reset asserted mid-operation clears state immediately, asynchronously. Writes and claims presented while rst=1 are lost.
- The first edge after rst deasserts operates normally.

## Configuration
- REGFILE_BYPASS_EN defined (write-first bypass): a read of rd_addr[p]==wr_addr with wr_en=1 in the same cycle returns wr_data. rd_busy[p] returns the post-edge busy value, i.e. 0 unless a same-cycle claim to that address also occurs. Address 0 is never bypassed.
- REGFILE_BYPASS_EN undefined (read-before-write): a same-cycle read returns the old entry value and the pre-edge busy bit.

## Test plan
- Reset: hold rst=1 with random writes presented → all rd_data=0, rd_busy=0, busy_any=0. After release, reading every address returns 0.
- Write/read: write 0xDEADBEEF to r5, then read r5 on port 0 and r5 on port 1 next cycle → both rd_data=0xDEADBEEF, rd_busy=0.
- Zero register: write 0x12345678 to r0 and claim r0 → reading r0 gives 0, rd_busy=0, busy_any=0.
- Scoreboard: claim r7 → the next read of r7 shows rd_busy=1 and busy_any=1. Write r7=0xA5 → the following read shows 0xA5, rd_busy=0, busy_any=0.
- Same-cycle claim and write: r9 is busy; write r9=0x55 and claim r9 in the same cycle → busy stays 1 and r9 reads 0x55.
- Same-cycle read and write: write r3=0x1, then in one cycle write r3=0x2 and read r3 → rd_data=0x2 with REGFILE_BYPASS_EN, 0x1 without it.
